// File: rtl/nonce_select.sv
// nonce_select
// -----------------------------------------------------------------------------
// Scans NUM_NONCES consecutive 32-bit hash words in memory. It reports the
// smallest word, its index (the lowest index wins on a tie), and whether any
// word was strictly below a target threshold.
//
// Optional build macro: NONCE_SELECT_WRITEBACK_EN
//   defined   -> after the scan, two result words are written to memory:
//                [result_addr]   = best_hash
//                [result_addr+1] = {found, 27'b0, best_nonce}
//   undefined -> no memory writes; mem_we and mem_write_data are tied low and
//                result_addr is ignored.
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset
//   start               begins a scan when seen in IDLE or DONE
//   hash_addr           base address of the hash words (word i = nonce i)
//   result_addr         base address of the result write-back
//   target              unsigned threshold, captured at start
//   done                scan (and write-back) complete; held until next start
//   found               some word was strictly below target
//   best_nonce          index of the minimum word
//   best_hash           value of the minimum word
//   mem_clk             memory clock (same as clk)
//   mem_we, mem_addr,   registered memory request; read data returns one
//   mem_write_data      cycle after the address is presented
//   mem_read_data       read data from the memory
//
// The compare runs as a short pipeline fed by the memory output register:
//   p0 : memory output register holds word idx_p0 (vld_p0)
//   p1 : word captured together with its below-target flag (vld_p1)
//   merge: p1 folded into best_hash/best_nonce/found
// DRAIN lasts until the last word has been merged.
// -----------------------------------------------------------------------------
module nonce_select #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [3:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    // Five bits so that the issue index can reach 16 without wrapping to 0.
    localparam int IDX_W  = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE0,
        WRITE1,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Issue side: index of the next address and tag of the address on mem_addr
    logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;
    logic [3:0]        iss_tag_q, iss_tag_d;
    logic              iss_vld_q, iss_vld_d;

    // Compare pipeline
    logic              vld_p0, vld_p1;
    logic [3:0]        idx_p0, idx_p1;
    logic [DATA_W-1:0] x_p1;
    logic              lt_tgt_p1;

    // Values captured at start
    logic [ADDR_W-1:0] hash_base_q;
    logic [DATA_W-1:0] target_q;

    // Results and memory request
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [3:0]        best_nonce_q, best_nonce_d;
    logic [DATA_W-1:0] best_hash_q, best_hash_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              accept;
    logic              last_merge;

`ifdef NONCE_SELECT_WRITEBACK_EN
    logic [ADDR_W-1:0] result_base_q;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
`else
    logic              unused_result_addr;
    assign unused_result_addr = ^result_addr;
`endif

    // A new scan may start from IDLE or, back to back, from DONE.
    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    // The final word is folded into the result at this edge.
    assign last_merge = (state_q == DRAIN) && vld_p1 && (idx_p1 == LAST_IDX[3:0]);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (iss_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_merge) begin
`ifdef NONCE_SELECT_WRITEBACK_EN
                    state_d = WRITE0;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef NONCE_SELECT_WRITEBACK_EN
            WRITE0: state_d = WRITE1;
            WRITE1: state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Issue counter
    // -------------------------------------------------------------------------
    always_comb begin
        iss_idx_d = iss_idx_q;
        iss_tag_d = iss_tag_q;
        iss_vld_d = 1'b0;
        if (accept) begin
            // Word 0 is issued on the start edge itself.
            iss_idx_d = IDX_W'(1);
            iss_tag_d = 4'd0;
            iss_vld_d = 1'b1;
        end else if (state_q == FETCH) begin
            iss_idx_d = iss_idx_q + IDX_W'(1);
            iss_tag_d = iss_idx_q[3:0];
            iss_vld_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Result merge: strict unsigned less-than keeps the earliest minimum
    // -------------------------------------------------------------------------
    always_comb begin
        best_hash_d  = best_hash_q;
        best_nonce_d = best_nonce_q;
        found_d      = found_q;
        if (accept) begin
            best_hash_d  = '1;
            best_nonce_d = 4'd0;
            found_d      = 1'b0;
        end else if (vld_p1) begin
            if (x_p1 < best_hash_q) begin
                best_hash_d  = x_p1;
                best_nonce_d = idx_p1;
            end
            if (lt_tgt_p1) begin
                found_d = 1'b1;
            end
        end
    end

    assign done_d = (state_d == DONE);

    // -------------------------------------------------------------------------
    // Memory request
    // -------------------------------------------------------------------------
    always_comb begin
`ifdef NONCE_SELECT_WRITEBACK_EN
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
`endif
        mem_addr_d  = '0;
        if (accept) begin
            mem_addr_d = hash_addr;
        end else if (state_q == FETCH) begin
            mem_addr_d = hash_base_q + ADDR_W'(iss_idx_q);
        end
`ifdef NONCE_SELECT_WRITEBACK_EN
        // The write data for WRITE0 uses the merged value so the final word
        // merged on the same edge is included.
        if (state_d == WRITE0) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = result_base_q;
            mem_wdata_d = best_hash_d;
        end else if (state_d == WRITE1) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = result_base_q + ADDR_W'(1);
            mem_wdata_d = {found_q, 27'b0, best_nonce_q};
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Control and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_idx_q    <= '0;
            iss_tag_q    <= 4'd0;
            iss_vld_q    <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            best_nonce_q <= 4'd0;
            best_hash_q  <= '1;
            mem_addr_q   <= '0;
`ifdef NONCE_SELECT_WRITEBACK_EN
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
`endif
        end else begin
            iss_idx_q    <= iss_idx_d;
            iss_tag_q    <= iss_tag_d;
            iss_vld_q    <= iss_vld_d;
            vld_p0       <= iss_vld_q;
            vld_p1       <= vld_p0;
            done_q       <= done_d;
            found_q      <= found_d;
            best_nonce_q <= best_nonce_d;
            best_hash_q  <= best_hash_d;
            mem_addr_q   <= mem_addr_d;
`ifdef NONCE_SELECT_WRITEBACK_EN
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Data registers (qualified by the valid bits, no reset needed)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            hash_base_q <= hash_addr;
            target_q    <= target;
`ifdef NONCE_SELECT_WRITEBACK_EN
            result_base_q <= result_addr;
`endif
        end
        // p0: tag follows the memory output register
        idx_p0    <= iss_tag_q;
        // p1: word and its below-target flag
        idx_p1    <= idx_p0;
        x_p1      <= mem_read_data;
        lt_tgt_p1 <= (mem_read_data < target_q);
    end

    assign mem_clk        = clk;
    assign mem_addr       = mem_addr_q;
    assign done           = done_q;
    assign found          = found_q;
    assign best_nonce     = best_nonce_q;
    assign best_hash      = best_hash_q;
`ifdef NONCE_SELECT_WRITEBACK_EN
    assign mem_we         = mem_we_q;
    assign mem_write_data = mem_wdata_q;
`else
    assign mem_we         = 1'b0;
    assign mem_write_data = '0;
`endif

endmodule

// File: tb/tb_nonce_select.sv
module tb_nonce_select;

    localparam int N = 16;
`ifdef NONCE_SELECT_WRITEBACK_EN
    localparam int LAT = N + 4;
    localparam int WE_PER_SCAN = 2;
`else
    localparam int LAT = N + 2;
    localparam int WE_PER_SCAN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [3:0]  best_nonce;
    logic [31:0] best_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    nonce_select #(.NUM_NONCES(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .hash_addr     (hash_addr),
        .result_addr   (result_addr),
        .target        (target),
        .done          (done),
        .found         (found),
        .best_nonce    (best_nonce),
        .best_hash     (best_hash),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    // Synchronous-read memory (one cycle latency); writes are logged.
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    logic [15:0] wlog_a [0:15];
    logic [31:0] wlog_d [0:15];
    int          we_cnt = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            wlog_a[we_cnt[3:0]] <= mem_addr;
            wlog_d[we_cnt[3:0]] <= mem_write_data;
            we_cnt <= we_cnt + 1;
        end
        rd_q <= mem[mem_addr];
    end
    assign mem_read_data = rd_q;

    typedef struct {
        int          kind;
        logic [15:0] res;
        logic [31:0] tgt;
        logic        fnd;
        logic [3:0]  nonce;
        logic [31:0] hash;
    } vec_t;

    typedef struct {
        logic        fnd;
        logic [3:0]  nonce;
        logic [31:0] hash;
        logic [15:0] res;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   scan_we0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fill(input int kind, input logic [15:0] base);
        logic [31:0] w;
        logic [15:0] a;
        for (int i = 0; i < N; i++) begin
            a = base + 16'(i);
            case (kind)
                0: w = 32'h9000_0000 - 32'(i);
                1: w = (i == 5 || i == 9) ? 32'h0000_0010 : 32'hFFFF_0000;
                2: w = (i == 3) ? 32'h1234_5678 : 32'h1234_5679 + 32'(i);
                3: w = 32'hFFFF_FFFF;
                4: w = (i == 0) ? 32'h0 : 32'd5 + 32'(i);
                5: w = (i == 15) ? 32'h7FFF_FFFF : 32'h8000_0000 + 32'(i);
                default: w = $urandom;
            endcase
            mem[a] = w;
        end
    endtask

    // Straightforward reference scan over the memory contents.
    task automatic model(input logic [15:0] base, input logic [31:0] tgt, output exp_t e);
        logic [31:0] x;
        e.fnd = 1'b0;
        e.nonce = 4'd0;
        e.hash = 32'hFFFF_FFFF;
        e.res = 16'h0;
        for (int i = 0; i < N; i++) begin
            x = mem[base + 16'(i)];
            if (x < e.hash) begin
                e.hash = x;
                e.nonce = 4'(i);
            end
            if (x < tgt) e.fnd = 1'b1;
        end
    endtask

    task automatic launch(input logic [15:0] base, input logic [15:0] res,
                          input logic [31:0] tgt, input exp_t e, input bit hold);
        hash_addr = base;
        result_addr = res;
        target = tgt;
        start = 1'b1;
        scan_we0 = we_cnt;
        e.res = res;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 4 * N + 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_scan(input string name);
        int   lat;
        exp_t e;
        wait_done(lat);
        check({name, " latency"}, lat, LAT);
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check({name, " found"}, {31'b0, found}, {31'b0, e.fnd});
            check({name, " best_nonce"}, {28'b0, best_nonce}, {28'b0, e.nonce});
            check({name, " best_hash"}, best_hash, e.hash);
            check({name, " write count"}, we_cnt - scan_we0, WE_PER_SCAN);
            check({name, " we idle"}, {31'b0, mem_we}, 0);
`ifdef NONCE_SELECT_WRITEBACK_EN
            check({name, " wb addr0"}, {16'b0, wlog_a[scan_we0 % 16]}, {16'b0, e.res});
            check({name, " wb data0"}, wlog_d[scan_we0 % 16], e.hash);
            check({name, " wb addr1"}, {16'b0, wlog_a[(scan_we0 + 1) % 16]}, {16'b0, e.res + 16'd1});
            check({name, " wb data1"}, wlog_d[(scan_we0 + 1) % 16], {e.fnd, 27'b0, e.nonce});
`endif
        end
    endtask

    vec_t vt[8];

    initial begin
        exp_t        e;
        logic [15:0] base;
        logic [31:0] tgt;
        int          w0;

        //             kind result     target        fnd   nonce  hash
        vt[0] = '{0, 16'h0210, 32'h8000_0000, 1'b0, 4'd15, 32'h8FFF_FFF1};
        vt[1] = '{1, 16'h0200, 32'h0000_0100, 1'b1, 4'd5,  32'h0000_0010};
        vt[2] = '{2, 16'h0220, 32'h1234_5678, 1'b0, 4'd3,  32'h1234_5678};
        vt[3] = '{3, 16'h0224, 32'hFFFF_FFFF, 1'b0, 4'd0,  32'hFFFF_FFFF};
        vt[4] = '{4, 16'h0228, 32'h0000_0000, 1'b0, 4'd0,  32'h0000_0000};
        vt[5] = '{5, 16'h022C, 32'h8000_0000, 1'b1, 4'd15, 32'h7FFF_FFFF};
        vt[6] = '{6, 16'h0230, 32'h0,         1'b0, 4'd0,  32'h0};
        vt[7] = '{6, 16'h0234, 32'h0,         1'b0, 4'd0,  32'h0};

        reset = 1'b1;
        start = 1'b0;
        hash_addr = 16'h0;
        result_addr = 16'h0;
        target = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst done", {31'b0, done}, 0);
        check("rst found", {31'b0, found}, 0);
        check("rst best_nonce", {28'b0, best_nonce}, 0);
        check("rst best_hash", best_hash, 32'hFFFF_FFFF);
        check("rst mem_we", {31'b0, mem_we}, 0);
        check("rst mem_addr", {16'b0, mem_addr}, 0);
        check("rst mem_write_data", mem_write_data, 0);
        check("mem_clk high", {31'b0, mem_clk}, 1);
        @(negedge clk);
        #1;
        check("mem_clk low", {31'b0, mem_clk}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table-driven scans
        for (int v = 0; v < 8; v++) begin
            base = 16'h0100 + 16'(v * 32);
            fill(vt[v].kind, base);
            tgt = (vt[v].kind == 6) ? $urandom : vt[v].tgt;
            if (vt[v].kind == 6) begin
                model(base, tgt, e);
            end else begin
                e.fnd = vt[v].fnd;
                e.nonce = vt[v].nonce;
                e.hash = vt[v].hash;
                e.res = vt[v].res;
            end
            launch(base, vt[v].res, tgt, e, 1'b0);
            finish_scan($sformatf("vec%0d", v));
        end

        // Reset wins over start in the same cycle
        hash_addr = 16'h0100;
        target = 32'h8000_0000;
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst+start mem_addr", {16'b0, mem_addr}, 0);
        check("rst+start done", {31'b0, done}, 0);
        start = 1'b0;
        reset = 1'b0;
        w0 = we_cnt;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("rst+start idle done", {31'b0, done}, 0);
        check("rst+start no writes", we_cnt - w0, 0);

        // Reset during FETCH at index 7 aborts the scan
        hash_addr = 16'h0100;
        result_addr = 16'h0240;
        target = 32'h8000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort done", {31'b0, done}, 0);
        check("abort found", {31'b0, found}, 0);
        check("abort best_nonce", {28'b0, best_nonce}, 0);
        check("abort best_hash", best_hash, 32'hFFFF_FFFF);
        check("abort mem_we", {31'b0, mem_we}, 0);
        check("abort mem_addr", {16'b0, mem_addr}, 0);
        check("abort mem_write_data", mem_write_data, 0);
        w0 = we_cnt;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("abort stays idle", {31'b0, done}, 0);
        check("abort best_hash held", best_hash, 32'hFFFF_FFFF);
        check("abort no writes", we_cnt - w0, 0);
        e.fnd = 1'b1;
        e.nonce = 4'd5;
        e.hash = 32'h0000_0010;
        launch(16'h0120, 16'h0200, 32'h0000_0100, e, 1'b0);
        finish_scan("after abort");

        // Back-to-back scans with start held high through DONE
        e.fnd = 1'b1;
        e.nonce = 4'd5;
        e.hash = 32'h0000_0010;
        launch(16'h0120, 16'h0200, 32'h0000_0100, e, 1'b1);
        finish_scan("b2b first");
        hash_addr = 16'h0100;
        result_addr = 16'h0210;
        target = 32'h8000_0000;
        e.fnd = 1'b0;
        e.nonce = 4'd15;
        e.hash = 32'h8FFF_FFF1;
        e.res = 16'h0210;
        sb.push_back(e);
        scan_we0 = we_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b done drops", {31'b0, done}, 0);
        finish_scan("b2b second");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
